// File: rtl/ahb_pkg.sv
// Shared AHB encodings and helpers for the SRAM responder.
// Byte-lane enables are derived here so the FSM only latches a 4-bit mask.
package ahb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY   = 2'b01,
        NONSEQ = 2'b10,
        SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [1:0] {
        OKAY  = 2'b00,
        ERROR = 2'b01,
        RETRY = 2'b10,
        SPLIT = 2'b11
    } hresp_e;

    localparam logic [2:0] SZ_BYTE = 3'd0;
    localparam logic [2:0] SZ_HALF = 3'd1;
    localparam logic [2:0] SZ_WORD = 3'd2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_DATA,
        S_ERR1,
        S_ERR2
    } resp_state_e;

    // Little-endian lane mask; only meaningful for legal (aligned, size <= word) transfers.
    function automatic logic [3:0] byte_en(input logic [2:0] size, input logic [1:0] addr_lo);
        case (size)
            SZ_BYTE: byte_en = 4'b0001 << addr_lo;
            SZ_HALF: byte_en = 4'b0011 << {addr_lo[1], 1'b0};
            default: byte_en = 4'hF;
        endcase
    endfunction

endpackage

// File: rtl/ahb_sram_mem.sv
// Word-wide storage with per-byte write enables and an asynchronous read port.
// Contents are deliberately left unreset.
module ahb_sram_mem #(
    parameter int MEM_DEPTH = 256,
    parameter int IDX_W     = $clog2(MEM_DEPTH)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [3:0]       be_i,
    input  logic [IDX_W-1:0] addr_i,
    input  logic [31:0]      wdata_i,
    output logic [31:0]      rdata_o
);

    logic [31:0] mem_q [MEM_DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int k = 0; k < 4; k++) begin
                if (be_i[k]) mem_q[addr_i][8*k +: 8] <= wdata_i[8*k +: 8];
            end
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/ahb_sram_responder.sv
// AHB responder backed by ahb_sram_mem: address decode, wait-state insertion and
// the two-cycle ERROR response, with pipelined address/data phases.
module ahb_sram_responder
    import ahb_pkg::*;
#(
    parameter int ADDR_W      = 12,
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_STATES = 1
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [31:0] HWDATA,
    output logic        HREADY,
    output logic [1:0]  HRESP,
    output logic [31:0] HRDATA
);

    localparam int         IDX_W   = $clog2(MEM_DEPTH);
    localparam logic [3:0] WS_LAST = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    resp_state_e      state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [3:0]       be_q, be_d;
    logic             write_q, write_d;

    logic              accept;
    logic              legal;
    logic [ADDR_W-3:0] word_off;
    logic [31:0]       mem_rdata;
    logic              mem_we;
    logic              unused_sig;

    // Burst type, the SEQ/NONSEQ distinction and bits above the window carry no meaning here.
    assign unused_sig = ^{HBURST, HTRANS[0], HADDR[31:ADDR_W]};

    assign word_off = HADDR[ADDR_W-1:2];
    assign accept   = HSEL && HTRANS[1] && HREADY;

    always_comb begin
        legal = 1'b1;
        if (HSIZE > SZ_WORD)                          legal = 1'b0;
        if (HSIZE == SZ_HALF && HADDR[0])             legal = 1'b0;
        if (HSIZE == SZ_WORD && HADDR[1:0] != 2'b00)  legal = 1'b0;
        if (32'(word_off) >= 32'(MEM_DEPTH))          legal = 1'b0;
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            be_q    <= '0;
            write_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            be_q    <= be_d;
            write_q <= write_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        be_d    = be_q;
        write_d = write_q;
        case (state_q)
            S_WAIT: begin
                if (cnt_q == 4'd0) state_d = S_DATA;
                else               cnt_d   = cnt_q - 4'd1;
            end
            S_ERR1: state_d = S_ERR2;
            // S_IDLE, S_DATA and S_ERR2 all drive HREADY high and may take a new address phase.
            default: begin
                state_d = S_IDLE;
                if (accept) begin
                    idx_d   = HADDR[IDX_W+1:2];
                    be_d    = byte_en(HSIZE, HADDR[1:0]);
                    write_d = HWRITE;
                    if (!legal) begin
                        state_d = S_ERR1;
                    end else if (WAIT_STATES > 0) begin
                        state_d = S_WAIT;
                        cnt_d   = WS_LAST;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
        endcase
    end

    always_comb begin
        HREADY = 1'b1;
        HRESP  = OKAY;
        HRDATA = '0;
        case (state_q)
            S_WAIT: HREADY = 1'b0;
            S_DATA: if (!write_q) HRDATA = mem_rdata;
            S_ERR1: begin
                HREADY = 1'b0;
                HRESP  = ERROR;
            end
            S_ERR2: HRESP = ERROR;
            default: ;
        endcase
    end

    assign mem_we = (state_q == S_DATA) && write_q;

    ahb_sram_mem #(
        .MEM_DEPTH (MEM_DEPTH),
        .IDX_W     (IDX_W)
    ) u_mem (
        .clk_i   (HCLK),
        .we_i    (mem_we),
        .be_i    (be_q),
        .addr_i  (idx_q),
        .wdata_i (HWDATA),
        .rdata_o (mem_rdata)
    );

endmodule

// File: doc/ahb_sram_responder.md
Name: ahb_sram_responder

Overview:
AHB responder (slave) that answers transfers from the existing ahb_master. It is backed by a byte-addressable word memory.
- Decodes the 4 KB window selected by HSEL.
- Inserts a configurable number of wait states.
- Issues the two-cycle ERROR response for illegal accesses.
- Pipelined address/data phases; back-to-back transfers are supported. Drop-in peer to ahb_slave on the shared bus.

Parameters:
- ADDR_W, 12, byte-offset bits decoded inside the HSEL window.
- MEM_DEPTH, 256, number of 32-bit words implemented; offsets at or above MEM_DEPTH*4 return ERROR.
- WAIT_STATES, 1, HREADY-low cycles inserted before each OKAY data phase (0..15).

Ports:
- HCLK  in  1  bus clock; all state changes on rising edge.
- HRESET  in  1  asynchronous, active-high reset.
- HSEL  in  1  slave select from address decoder.
- HADDR  in  32  transfer address.
- HTRANS  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- HWRITE  in  1  1=write, 0=read.
- HSIZE  in  3  0=byte, 1=half, 2=word; larger values are illegal.
- HBURST  in  3  accepted but ignored; every beat is treated independently.
- HWDATA  in  32  write data, valid in the data phase.
- HREADY  out  1  transfer done / bus ready.
- HRESP  out  2  OKAY=00, ERROR=01; RETRY/SPLIT are never issued.
- HRDATA  out  32  read data.

Behaviour:
- Reset (async assert, sync release): HREADY=1, HRESP=00, HRDATA=0, FSM=S_IDLE, wait counter=0, latched address-phase registers cleared. Memory contents are not cleared. A transfer in flight is abandoned and no write commits.
- Address phase accepted at a rising edge when HSEL && HTRANS[1] && HREADY==1 (own output). At that edge latch word index, byte lane, size, write flag and legality.
- IDLE/BUSY, or HSEL=0 with HREADY=1: no action. The next cycle is a zero-wait OKAY with no memory access.
- Legality: illegal if HSIZE>2, or misaligned (half with HADDR[0]=1, word with HADDR[1:0]!=0), or HADDR[ADDR_W-1:2] >= MEM_DEPTH.
- FSM:
  - S_IDLE: HREADY=1, HRESP=00. On an accepted legal transfer, go to S_WAIT if WAIT_STATES>0, else S_DATA. On an accepted illegal transfer, go to S_ERR1.
  - S_WAIT: HREADY=0, HRESP=00. Counter counts WAIT_STATES cycles, then go to S_DATA.
  - S_DATA: HREADY=1, HRESP=00; the data phase completes at this edge. A simultaneous new address phase is accepted and handled exactly as from S_IDLE; otherwise go to S_IDLE.
  - S_ERR1: HREADY=0, HRESP=01. Address inputs are ignored. Unconditionally go to S_ERR2.
  - S_ERR2: HREADY=1, HRESP=01. May accept a new address phase, with the same rules as S_IDLE; otherwise go to S_IDLE.
- Latency: an OKAY transfer completes WAIT_STATES+1 cycles after address acceptance. ERROR always takes exactly 2 cycles regardless of WAIT_STATES.
- Write: bytes are committed at the S_DATA edge using HWDATA and byte enables.
  - Byte enables: size 0 gives 1<<HADDR[1:0]; size 1 gives 4'b0011<<{HADDR[1],1'b0}; size 2 gives 4'hF.
  - Little-endian lanes: lane k maps to HWDATA[8k+7:8k].
  - A failed or ERROR transfer never writes.
- Read: HRDATA = full stored word at the latched index while in S_DATA for a read; 0 in every other state. Unselected lanes are not masked.
- Back-to-back write then read to the same address returns the new data, because the write commits at the edge that starts the read's data phase.
- The FSM never stalls in S_WAIT longer than WAIT_STATES cycles. HRESP=01 appears only in S_ERR1/S_ERR2.

Decomposition:
- Shared package ahb_pkg:
  - htrans_e {IDLE, BUSY, NONSEQ, SEQ}
  - hresp_e {OKAY, ERROR, RETRY, SPLIT}
  - hsize constants SZ_BYTE/SZ_HALF/SZ_WORD
  - resp_state_e {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2}
  - function byte_en(size, addr_lo)
- Sub-module ahb_sram_mem: MEM_DEPTH x 32 array with 4-bit byte-enable write port and combinational read port. The FSM and decode live in the top level.

Test Plan:
- WAIT_STATES=1: NONSEQ word write 0x100 data 0x12345678, then NONSEQ read 0x100 -> each data phase has 1 HREADY-low cycle then HREADY=1 OKAY; read HRDATA=0x12345678.
- WAIT_STATES=0: back-to-back byte writes 0xAA to 0x201 and 0xBB to 0x203, then word read 0x200 -> zero-wait OKAY every cycle; HRDATA=0xBB00AA00 after a prior word write of 0.
- Word read at 0x102 (misaligned) -> S_ERR1 (HREADY=0, HRESP=01) then S_ERR2 (HREADY=1, HRESP=01); memory unchanged; next IDLE gives OKAY.
- Write to 0x800 (index 512 >= 256) with HSIZE=2 -> two-cycle ERROR; a subsequent read of 0x000 returns the prior value.
- HSIZE=3 read at 0x000 -> two-cycle ERROR. IDLE and BUSY beats with HSEL=1 -> HREADY=1, HRESP=00, HRDATA=0.
- Assert HRESET during S_WAIT of a write to 0x10 -> HREADY=1, HRESP=00, HRDATA=0 immediately (async); after release a read of 0x10 returns the old data.
